// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants for the 4-digit timer: FSM state encoding, state width and
// the default timing parameters (10 MHz clock). The timer core reuses the
// defaults so both halves agree on tick rate.
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'b01;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'b10;
  localparam logic [STATE_W-1:0] ST_LAP   = 2'b11;

  // 20 ms of stable level at 10 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 200000;
  // 1 Hz count tick at 10 MHz.
  localparam int DEFAULT_PRESCALE        = 10000000;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw asynchronous push-button: 2-flop synchroniser, stability
// counter, and a registered one-cycle pulse on an accepted 0->1 transition.
// Releases produce no pulse. Press appears 2 + DEBOUNCE_CYCLES + 1 edges after
// the first edge that samples raw high (raw held high throughout).
//
// Ports:
//   clk    in   system clock
//   rst    in   async active-high reset
//   raw    in   raw button level, active-high, asynchronous
//   press  out  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; +1 keeps width >= 1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          stable_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive synced samples differing from the current stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r    <= {CW{1'b0}};
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CW'(1);
    end
  end

  // Rising-edge detect on the stable level, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d_r <= 1'b0;
      press_r    <= 1'b0;
    end else begin
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Front-end control for the 4-digit timer. Debounces the three buttons, runs
// the IDLE/RUN/PAUSE/LAP state machine and produces the count-enable tick.
//
// Ports:
//   clk             in   system clock
//   rst             in   async active-high reset
//   btn_start_stop  in   raw button, active-high
//   btn_clear       in   raw button, active-high
//   btn_lap         in   raw button, active-high
//   tick            out  one-cycle count-enable pulse every PRESCALE cycles
//   clear           out  one-cycle pulse: timer core zeroes its digits
//   run             out  high in RUN or LAP
//   hold            out  high in LAP (display frozen, counting continues)
//   state           out  current FSM state (debug)
// -----------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PRESCALE        = DEFAULT_PRESCALE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start_stop,
  input  logic               btn_clear,
  input  logic               btn_lap,
  output logic               tick,
  output logic               clear,
  output logic               run,
  output logic               hold,
  output logic [STATE_W-1:0] state
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic               ss_press_s;
  logic               cl_press_s;
  logic               lp_press_s;

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_nxt_s;
  logic               clear_nxt_s;
  logic               run_nxt_s;
  logic               hold_nxt_s;

  logic               run_r;
  logic               hold_r;
  logic               clear_r;
  logic               tick_r;
  logic [PW-1:0]      ps_cnt_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_start_stop),
    .press (ss_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_cl (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clear),
    .press (cl_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lp (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_lap),
    .press (lp_press_s)
  );

  // State register plus the outputs registered from next-state, so every
  // output moves on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
      hold_r  <= 1'b0;
      clear_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
      hold_r  <= hold_nxt_s;
      clear_r <= clear_nxt_s;
    end
  end

  // Next-state logic. Priority clear > start_stop > lap; an event that a
  // state ignores does not mask lower-priority events.
  always_comb begin
    state_nxt_s = state_r;
    clear_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cl_press_s) begin
          clear_nxt_s = 1'b1;
        end else if (ss_press_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ss_press_s) begin
          state_nxt_s = ST_PAUSE;
        end else if (lp_press_s) begin
          state_nxt_s = ST_LAP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (ss_press_s) begin
          state_nxt_s = ST_PAUSE;
        end else if (lp_press_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (cl_press_s) begin
          state_nxt_s = ST_IDLE;
          clear_nxt_s = 1'b1;
        end else if (ss_press_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from next-state.
  always_comb begin
    run_nxt_s  = 1'b0;
    hold_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN: begin
        run_nxt_s  = 1'b1;
      end
      ST_LAP: begin
        run_nxt_s  = 1'b1;
        hold_nxt_s = 1'b1;
      end
      default: begin
        run_nxt_s  = 1'b0;
        hold_nxt_s = 1'b0;
      end
    endcase
  end

  // Prescaler: advances while run is high and holds in PAUSE so resume keeps
  // phase. A wrap on the edge that leaves run suppresses the tick so tick is
  // never seen with run low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt_r <= {PW{1'b0}};
      tick_r   <= 1'b0;
    end else if (clear_nxt_s || (state_r == ST_IDLE)) begin
      ps_cnt_r <= {PW{1'b0}};
      tick_r   <= 1'b0;
    end else if (run_r) begin
      if (ps_cnt_r == PS_LAST) begin
        ps_cnt_r <= {PW{1'b0}};
        tick_r   <= run_nxt_s;
      end else begin
        ps_cnt_r <= ps_cnt_r + PW'(1);
        tick_r   <= 1'b0;
      end
    end else begin
      tick_r   <= 1'b0;
    end
  end

  assign tick  = tick_r;
  assign clear = clear_r;
  assign run   = run_r;
  assign hold  = hold_r;
  assign state = state_r;

endmodule
